// File: rtl/apb_timer_slave.sv
// APB3 completer with a prescaled 32-bit down-counter (auto-reload, expiry flag, irq) and scratch register.
// Optional macro APB_TIMER_WAIT_STATE_EN inserts one wait state into every transfer.
module apb_timer_slave #(
   parameter int          PRESCALE_W   = 16,
   parameter logic [31:0] RESET_RELOAD = 32'hFFFF_FFFF
) (
   input  logic        io_systemClk,
   input  logic        io_systemReset,
   input  logic [15:0] io_apbSlave_PADDR,
   input  logic        io_apbSlave_PSEL,
   input  logic        io_apbSlave_PENABLE,
   input  logic        io_apbSlave_PWRITE,
   input  logic [31:0] io_apbSlave_PWDATA,
   output logic [31:0] io_apbSlave_PRDATA,
   output logic        io_apbSlave_PREADY,
   output logic        io_apbSlave_PSLVERROR,
   output logic        io_timerIrq,
   output logic        io_timerTick
);

   logic                  en_q, en_d, autoreload_q, autoreload_d, irqen_q, irqen_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d, pc_q, pc_d;
   logic [31:0]           reload_q, reload_d, count_q, count_d, scratch_q, scratch_d;
   logic                  expired_q, expired_d, irq_q, irq_d, tick_q, tick_d;

   logic        access, addr_ok, wr_en, pready;
   logic [2:0]  reg_sel;
   logic [31:0] rdata_dec;
   logic        ctrl_wr, prescale_wr, reload_wr, count_wr, status_wr, scratch_wr;
   logic        tick_pre, expire;
   logic        unused_addr_bits;

   assign access           = io_apbSlave_PSEL & io_apbSlave_PENABLE & ~io_systemReset;
   assign reg_sel          = io_apbSlave_PADDR[4:2];
   assign addr_ok          = (io_apbSlave_PADDR[15:5] == 11'd0) && (reg_sel <= 3'd5);
   assign unused_addr_bits = ^io_apbSlave_PADDR[1:0];

   always_comb begin
      rdata_dec = '0;
      case (reg_sel)
         3'd0:    rdata_dec = {29'd0, irqen_q, autoreload_q, en_q};
         3'd1:    rdata_dec = 32'(prescale_q);
         3'd2:    rdata_dec = reload_q;
         3'd3:    rdata_dec = count_q;
         3'd4:    rdata_dec = {31'd0, expired_q};
         3'd5:    rdata_dec = scratch_q;
         default: rdata_dec = '0;
      endcase
      if (!addr_ok) rdata_dec = '0;
   end

`ifdef APB_TIMER_WAIT_STATE_EN
   // First access cycle captures the decode; the second one completes the transfer.
   logic        wait_q, wait_d, pslverr_q, pslverr_d;
   logic [31:0] prdata_q, prdata_d;

   always_comb begin
      wait_d    = access & ~wait_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      if (access && !wait_q) begin
         prdata_d  = rdata_dec;
         pslverr_d = ~addr_ok;
      end
   end

   always_ff @(posedge io_systemClk) begin
      if (io_systemReset) begin
         wait_q    <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign pready                = access & wait_q;
   assign io_apbSlave_PRDATA    = pready ? prdata_q : '0;
   assign io_apbSlave_PSLVERROR = pready & pslverr_q;
`else
   assign pready                = access;
   assign io_apbSlave_PRDATA    = access ? rdata_dec : '0;
   assign io_apbSlave_PSLVERROR = access & ~addr_ok;
`endif

   assign io_apbSlave_PREADY = pready;
   assign wr_en       = pready & io_apbSlave_PWRITE & addr_ok;
   assign ctrl_wr     = wr_en & (reg_sel == 3'd0);
   assign prescale_wr = wr_en & (reg_sel == 3'd1);
   assign reload_wr   = wr_en & (reg_sel == 3'd2);
   assign count_wr    = wr_en & (reg_sel == 3'd3);
   assign status_wr   = wr_en & (reg_sel == 3'd4);
   assign scratch_wr  = wr_en & (reg_sel == 3'd5);

   // A COUNT write on a tick cycle suppresses both the decrement and the expiry.
   assign tick_pre = en_q & (pc_q == prescale_q);
   assign expire   = tick_pre & (count_q == 32'd0) & ~count_wr;

   always_comb begin
      en_d         = en_q;
      autoreload_d = autoreload_q;
      irqen_d      = irqen_q;
      prescale_d   = prescale_q;
      reload_d     = reload_q;
      count_d      = count_q;
      scratch_d    = scratch_q;
      pc_d         = pc_q;
      expired_d    = expired_q;
      tick_d       = 1'b0;

      if (en_q) begin
         pc_d = tick_pre ? '0 : pc_q + 1'b1;
         if (tick_pre && count_q != 32'd0) count_d = count_q - 32'd1;
      end

      if (status_wr && io_apbSlave_PWDATA[0]) expired_d = 1'b0;

      if (expire) begin
         expired_d = 1'b1;
         tick_d    = 1'b1;
         if (autoreload_q) count_d = reload_q;
         else              en_d    = 1'b0;
      end

      if (ctrl_wr) begin
         en_d         = io_apbSlave_PWDATA[0];
         autoreload_d = io_apbSlave_PWDATA[1];
         irqen_d      = io_apbSlave_PWDATA[2];
         if (io_apbSlave_PWDATA[0] && !en_q) pc_d = '0;
      end
      if (prescale_wr) prescale_d = io_apbSlave_PWDATA[PRESCALE_W-1:0];
      if (reload_wr)   reload_d   = io_apbSlave_PWDATA;
      if (scratch_wr)  scratch_d  = io_apbSlave_PWDATA;
      if (count_wr) begin
         count_d = io_apbSlave_PWDATA;
         pc_d    = '0;
      end

      irq_d = expired_d & irqen_d;
   end

   always_ff @(posedge io_systemClk) begin
      if (io_systemReset) begin
         en_q         <= 1'b0;
         autoreload_q <= 1'b0;
         irqen_q      <= 1'b0;
         prescale_q   <= '0;
         reload_q     <= RESET_RELOAD;
         count_q      <= '0;
         scratch_q    <= '0;
         pc_q         <= '0;
         expired_q    <= 1'b0;
         irq_q        <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         en_q         <= en_d;
         autoreload_q <= autoreload_d;
         irqen_q      <= irqen_d;
         prescale_q   <= prescale_d;
         reload_q     <= reload_d;
         count_q      <= count_d;
         scratch_q    <= scratch_d;
         pc_q         <= pc_d;
         expired_q    <= expired_d;
         irq_q        <= irq_d;
         tick_q       <= tick_d;
      end
   end

   assign io_timerIrq  = irq_q;
   assign io_timerTick = tick_q;

endmodule
